// File: rtl/ripple_cnt_sampler.sv
// Samples an asynchronous 4-bit ripple counter into the clk domain, filters
// ripple transients and reports increments, skipped counts and wraps.
module ripple_cnt_sampler #(
  parameter int STABLE_CYC = 2,
  parameter int EXT_W      = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       cnt_in,
  input  logic             en,
  input  logic [3:0]       match_val,
  output logic [3:0]       cnt_sync,
  output logic             cnt_valid,
  output logic [EXT_W-1:0] ext_cnt,
  output logic             wrap_pulse,
  output logic             match_pulse,
  output logic             err_skip
);

  typedef enum logic [1:0] {INIT, TRACK, HOLD} state_t;

  localparam logic [3:0] STABLE_MAX = 4'(STABLE_CYC);

  state_t           state, state_n;
  logic [3:0]       s1, s2, s2_d;
  logic [3:0]       stable_cnt;
  logic [3:0]       sync_n;
  logic [EXT_W-1:0] ext_n;
  logic             valid_n, wrap_n, match_n, skip_n;
  logic             accept;
  logic [3:0]       delta;

  // Synchroniser and stability filter run regardless of the tracking state.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, which is what makes s1->s2->s2_d a shift chain.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1         <= '0;
      s2         <= '0;
      s2_d       <= '0;
      stable_cnt <= '0;
    end else begin
      s1   <= cnt_in;
      s2   <= s1;
      s2_d <= s2;
      if (s2 == s2_d)
        stable_cnt <= (stable_cnt >= STABLE_MAX) ? STABLE_MAX : stable_cnt + 4'd1;
      else
        stable_cnt <= '0;
    end
  end

  assign accept = (stable_cnt == STABLE_MAX) && (state == INIT || s2_d != cnt_sync) && en;
  assign delta  = s2_d - cnt_sync;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= INIT;
      cnt_sync    <= '0;
      cnt_valid   <= 1'b0;
      ext_cnt     <= '0;
      wrap_pulse  <= 1'b0;
      match_pulse <= 1'b0;
      err_skip    <= 1'b0;
    end else begin
      state       <= state_n;
      cnt_sync    <= sync_n;
      cnt_valid   <= valid_n;
      ext_cnt     <= ext_n;
      wrap_pulse  <= wrap_n;
      match_pulse <= match_n;
      err_skip    <= skip_n;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a variable unassigned and infer a latch.
  always_comb begin
    state_n = state;
    sync_n  = cnt_sync;
    valid_n = cnt_valid;
    ext_n   = ext_cnt;
    wrap_n  = 1'b0;
    match_n = 1'b0;
    skip_n  = 1'b0;

    if (!en) begin
      state_n = HOLD;
      valid_n = 1'b0;
    end else begin
      case (state)
        INIT: begin
          if (accept) begin
            sync_n  = s2_d;
            valid_n = 1'b1;
            state_n = TRACK;
          end
        end
        TRACK: begin
          if (accept) begin
            sync_n  = s2_d;
            match_n = (s2_d == match_val);
            // A skip that lands below the old value must have crossed zero.
            if (delta == 4'd1) begin
              wrap_n = (cnt_sync == 4'hF);
            end else begin
              skip_n = 1'b1;
              wrap_n = (s2_d < cnt_sync);
            end
            if (wrap_n)
              ext_n = ext_cnt + EXT_W'(1);
          end
        end
        HOLD: begin
          valid_n = 1'b0;
          state_n = INIT;
        end
        default: state_n = INIT;
      endcase
    end
  end

endmodule

// File: doc/ripple_cnt_sampler.md
Name: ripple_cnt_sampler

Overview:
Downstream consumer of the 4-bit asynchronous ripple up-counter. It brings the counter's unsynchronised, ripple-skewed output into the system clock domain. A 2-flop synchroniser and a stability filter remove ripple transients, and each settled value is checked for normal increment, skipped counts and wrap-around. Outputs are a clean registered count, a wrap-extended upper count, and single-cycle event pulses for the control logic.

Parameters:
STABLE_CYC, 2, consecutive equal synchronised samples required before a value is accepted (legal range 1..15).
EXT_W, 4, width of the wrap-extension counter.

Ports:
clk  input  1  system sampling clock. Independent of the ripple counter's clock.
rst  input  1  asynchronous, active-low reset.
cnt_in  input  4  ripple counter q outputs. Asynchronous to clk.
en  input  1  tracking enable, synchronous.
match_val  input  4  compare value for match_pulse, synchronous.
cnt_sync  output  4  last accepted count.
cnt_valid  output  1  high while in TRACK.
ext_cnt  output  EXT_W  number of detected wraps, mod 2^EXT_W.
wrap_pulse  output  1  one-cycle pulse when an accepted value wraps 15->0 or crosses zero.
match_pulse  output  1  one-cycle pulse when the accepted value equals match_val.
err_skip  output  1  one-cycle pulse when an accepted value advanced by more than 1.

Behaviour:
- Reset (rst=0, asynchronous): clears s1, s2, s2_d, stable_cnt, cnt_sync, ext_cnt and all pulses to 0; cnt_valid=0; state=INIT. The block leaves reset on the first clk edge after rst rises.
- Synchroniser: s1<=cnt_in; s2<=s1; s2_d<=s2. These registers run in every state.
- Stability counter, per edge: if s2==s2_d, stable_cnt<=min(stable_cnt+1, STABLE_CYC); else stable_cnt<=0.
- accept (combinational) = (stable_cnt==STABLE_CYC) && (state==INIT || s2_d!=cnt_sync) && en.
- Latency: cnt_in settles before edge E0. With no further change, cnt_sync takes the new value at edge E(STABLE_CYC+3), i.e. E5 at default. Event pulses assert on that same edge.
- Any transient on cnt_in shorter than STABLE_CYC+1 clk periods is never accepted.
- State INIT: on accept, cnt_sync<=s2_d, cnt_valid<=1, go to TRACK. No pulses; ext_cnt unchanged.
- State TRACK: on accept, new=s2_d, old=cnt_sync, d=(new-old) mod 16 (4-bit wrap arithmetic); cnt_sync<=new.
  - d==1: normal step. If old==15, wrap_pulse=1 and ext_cnt+1.
  - d>=2: err_skip=1. If new<old, wrap_pulse=1 and ext_cnt+1 (at most one wrap counted per accept).
  - match_pulse=1 when new==match_val, for either d case.
  - d==0 cannot occur, because accept requires a change.
- Any state with en=0: next state HOLD. In HOLD, cnt_valid=0, cnt_sync and ext_cnt hold, all pulses 0, no accept.
- HOLD with en=1: go to INIT, which re-seeds from the next stable value without pulses. ext_cnt is preserved.
- Pulses are registered and last exactly one cycle. All three may assert on the same edge.
- ext_cnt wraps from 2^EXT_W-1 to 0 silently.
- match_val is sampled on the accept edge only.
- Reset mid-operation aborts everything immediately. The first accepted value after reset only seeds cnt_sync.

Test Plan:
1. Reset and seed: hold rst=0, then release with cnt_in=0 stable. Required: all outputs 0 during reset; cnt_sync=0 and cnt_valid=1 at E5; no pulses.
2. Normal count with wrap: step cnt_in 0..15,0, with each value held 8 clk cycles. Required: cnt_sync follows every value; wrap_pulse exactly once (15->0); ext_cnt=1; err_skip never set.
3. Ripple glitch: cnt_in 7->6->4->0->8, each intermediate held 1 cycle, then 8 held stable. Required: single accept of 8; cnt_sync goes 7->8; no err_skip; no wrap_pulse.
4. Skip and match: match_val=6; cnt_in 3 (stable) then 6 (stable). Required: err_skip=1 and match_pulse=1 on the same edge; cnt_sync=6.
5. Skip across zero: cnt_in 14 then 2. Required: err_skip=1, wrap_pulse=1, ext_cnt increments by exactly 1.
6. Enable and async reset: drop en for 10 cycles while cnt_in changes 5->9, then raise en. Required: cnt_valid=0 and cnt_sync held at 5 during HOLD; re-seed to 9 with no pulses. Then pulse rst=0 between clk edges: all outputs 0 immediately, ext_cnt cleared.
